// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, instruction-memory and IF/DE signals of the fetch stage
interface fetch_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;
    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_addr_o, if_pc_o, if_inst_o, if_valid_o, misalign_o, fetch_count_o
    );
    modport master (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_addr_o, if_pc_o, if_inst_o, if_valid_o, misalign_o, fetch_count_o
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/DE pipeline register with stall, redirect/flush and misalign flag
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst,
    fetch_stage_if.slave bus
);
    logic [31:0] r_pc, r_if_pc, r_if_inst, r_count;
    logic        r_if_valid, r_misalign;
    assign bus.imem_addr_o   = r_pc;
    assign bus.if_pc_o       = r_if_pc;
    assign bus.if_inst_o     = r_if_inst;
    assign bus.if_valid_o    = r_if_valid;
    assign bus.misalign_o    = r_misalign;
    assign bus.fetch_count_o = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else if (bus.redirect_i) begin
            // the word fetched this cycle is dropped; target is force-aligned
            r_pc       <= {bus.redirect_pc_i[31:2], 2'b00};
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_misalign <= |bus.redirect_pc_i[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (!bus.stall_i) begin
                r_pc       <= r_pc + 32'd4;
                r_if_pc    <= r_pc;
                r_if_inst  <= bus.imem_data_i;
                r_if_valid <= 1'b1;
                r_count    <= r_count + 32'd1;
            end
        end
    end
endmodule
